// File: rtl/tdm_pkg.sv
// Shared definitions for the 1-to-16 TDM demultiplexer: frame geometry,
// lock-state encoding and overrun counter width.
package tdm_pkg;

    localparam int N_LANES   = 16;
    localparam int SEL_W     = 4;
    localparam int OVR_CNT_W = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_frame_buf.sv
// One-entry valid/ready holding register for assembled TDM frames.
// A completed frame is loaded when the slot is empty or drained this cycle; otherwise it is dropped.
module tdm_frame_buf
    import tdm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_req,
    input  logic [N_LANES-1:0] load_word,
    input  logic               frame_ready,
    output logic [N_LANES-1:0] frame_o,
    output logic               frame_valid,
    output logic               overrun
);

    logic slot_free;

    // A consumer taking the held frame frees the slot in the same cycle, so a new load wins.
    assign slot_free = !frame_valid || frame_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_o     <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= load_req && !slot_free;
            if (load_req && slot_free) begin
                frame_o     <= load_word;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tdm_demux_1to16.sv
// Receive-side 1-to-16 TDM demultiplexer: sync-locked slot counter, lane registers and frame assembly.
// Optional build macro TDM_DEMUX_OVR_CNT_EN adds a saturating ovr_cnt of overrun and sync_err pulses.
module tdm_demux_1to16
    import tdm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_bit,
    input  logic               in_valid,
    input  logic               in_sync,
    output logic [SEL_W-1:0]   sel_o,
    output logic               locked_o,
    output logic [N_LANES-1:0] lane_o,
    output logic [N_LANES-1:0] frame_o,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               sync_err,
    output logic               overrun
`ifdef TDM_DEMUX_OVR_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0] ovr_cnt
`endif
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_d;
    logic [N_LANES-1:0] lane_d;
    logic [N_LANES-1:0] asm_q, asm_d;
    logic               sync_err_d;
    logic               frame_done;

    assign locked_o = (state_q == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            sel_o    <= '0;
            lane_o   <= '0;
            asm_q    <= '0;
            sync_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_o    <= sel_d;
            lane_o   <= lane_d;
            asm_q    <= asm_d;
            sync_err <= sync_err_d;
        end
    end

    // Slot 0 (by count or by a sync strobe) always restarts assembly, discarding any partial frame.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_o;
        lane_d     = lane_o;
        asm_d      = asm_q;
        sync_err_d = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            HUNT: begin
                if (in_valid && in_sync) begin
                    state_d   = LOCKED;
                    sel_d     = SEL_W'(1);
                    lane_d[0] = in_bit;
                    asm_d     = {{(N_LANES-1){1'b0}}, in_bit};
                end
            end
            LOCKED: begin
                if (in_valid) begin
                    if (in_sync || sel_o == '0) begin
                        sync_err_d = in_sync && (sel_o != '0);
                        sel_d      = SEL_W'(1);
                        lane_d[0]  = in_bit;
                        asm_d      = {{(N_LANES-1){1'b0}}, in_bit};
                    end else begin
                        lane_d[sel_o] = in_bit;
                        asm_d[sel_o]  = in_bit;
                        sel_d         = sel_o + 1'b1;
                        frame_done    = (sel_o == SEL_W'(N_LANES-1));
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    tdm_frame_buf u_frame_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_req    (frame_done),
        .load_word   (asm_d),
        .frame_ready (frame_ready),
        .frame_o     (frame_o),
        .frame_valid (frame_valid),
        .overrun     (overrun)
    );

`ifdef TDM_DEMUX_OVR_CNT_EN
    logic [OVR_CNT_W:0] ovr_sum;

    assign ovr_sum = {1'b0, ovr_cnt} + (OVR_CNT_W+1)'(sync_err) + (OVR_CNT_W+1)'(overrun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt <= '0;
        end else begin
            ovr_cnt <= ovr_sum[OVR_CNT_W] ? '1 : ovr_sum[OVR_CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux_1to16.sv
// Directed self-checking bench for tdm_demux_1to16: lock, assembly, overrun, sync error, gaps, reset.
module tb_tdm_demux_1to16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_bit;
    logic        in_valid;
    logic        in_sync;
    logic [3:0]  sel_o;
    logic        locked_o;
    logic [15:0] lane_o;
    logic [15:0] frame_o;
    logic        frame_valid;
    logic        frame_ready;
    logic        sync_err;
    logic        overrun;
`ifdef TDM_DEMUX_OVR_CNT_EN
    logic [7:0]  ovr_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_demux_1to16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .in_sync     (in_sync),
        .sel_o       (sel_o),
        .locked_o    (locked_o),
        .lane_o      (lane_o),
        .frame_o     (frame_o),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sync_err    (sync_err),
        .overrun     (overrun)
`ifdef TDM_DEMUX_OVR_CNT_EN
        ,
        .ovr_cnt     (ovr_cnt)
`endif
    );

    task automatic beat(input logic b, input logic s);
        in_bit   = b;
        in_sync  = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sync  = 1'b1;
        in_bit   = ~in_bit;
        @(posedge clk);
        #1;
        in_sync  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] word, output int ovr_seen, output int serr_seen);
        ovr_seen  = 0;
        serr_seen = 0;
        for (int i = 0; i < 16; i++) begin
            beat(word[i], i == 0);
            ovr_seen  += int'(overrun);
            serr_seen += int'(sync_err);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        in_sync     = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({sel_o, locked_o, lane_o, frame_o, frame_valid, sync_err, overrun} !== 40'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got sel=%0d locked=%b lane=%h frame=%h fv=%b serr=%b ovr=%b, want all 0",
                     sel_o, locked_o, lane_o, frame_o, frame_valid, sync_err, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (locked_o !== 1'b0 || sel_o !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got locked=%b sel=%0d, want 0/0", locked_o, sel_o);
        end
    endtask

    task automatic test_hunt();
        for (int i = 0; i < 20; i++) begin
            beat(1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (locked_o !== 1'b0 || lane_o !== 16'h0 || frame_valid !== 1'b0 || sel_o !== 4'd0) begin
                n_fail++;
                $display("[TB] FAIL hunt_ignore beat %0d: got locked=%b lane=%h fv=%b sel=%0d, want 0/0000/0/0",
                         i, locked_o, lane_o, frame_valid, sel_o);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] w;
        w = 16'hA5C3;
        frame_ready = 1'b1;
        beat(w[0], 1'b1);
        n_checks++;
        if (locked_o !== 1'b1 || sel_o !== 4'd1) begin
            n_fail++;
            $display("[TB] FAIL lock_on_sync: got locked=%b sel=%0d, want 1/1", locked_o, sel_o);
        end
        for (int i = 1; i < 15; i++) beat(w[i], 1'b0);
        n_checks++;
        if (frame_valid !== 1'b0 || sel_o !== 4'd15) begin
            n_fail++;
            $display("[TB] FAIL pre_complete: got fv=%b sel=%0d, want 0/15", frame_valid, sel_o);
        end
        beat(w[15], 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || frame_o !== 16'hA5C3 || lane_o !== 16'hA5C3 || sel_o !== 4'd0 || locked_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL frame_a5c3: got fv=%b frame=%h lane=%h sel=%0d locked=%b, want 1/a5c3/a5c3/0/1",
                     frame_valid, frame_o, lane_o, sel_o, locked_o);
        end
        idle();
        n_checks++;
        if (frame_valid !== 1'b0 || frame_o !== 16'hA5C3) begin
            n_fail++;
            $display("[TB] FAIL consume: got fv=%b frame=%h, want 0/a5c3", frame_valid, frame_o);
        end
    endtask

    task automatic test_overrun();
        int ov1, ov2, se;
        frame_ready = 1'b0;
        send_frame(16'h1234, ov1, se);
        n_checks++;
        if (frame_valid !== 1'b1 || frame_o !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL first_load: got fv=%b frame=%h, want 1/1234", frame_valid, frame_o);
        end
        send_frame(16'hFFFF, ov2, se);
        n_checks++;
        if (overrun !== 1'b1 || frame_o !== 16'h1234 || lane_o !== 16'hFFFF) begin
            n_fail++;
            $display("[TB] FAIL overrun_drop: got ovr=%b frame=%h lane=%h, want 1/1234/ffff", overrun, frame_o, lane_o);
        end
        n_checks++;
        if (ov1 + ov2 !== 1) begin
            n_fail++;
            $display("[TB] FAIL overrun_count: got %0d pulses, want 1", ov1 + ov2);
        end
        idle();
        n_checks++;
        if (overrun !== 1'b0 || frame_valid !== 1'b1 || frame_o !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL overrun_hold: got ovr=%b fv=%b frame=%h, want 0/1/1234", overrun, frame_valid, frame_o);
        end
        frame_ready = 1'b1;
        idle();
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overrun_drain: got fv=%b, want 0", frame_valid);
        end
    endtask

    task automatic test_sync_err();
        logic [15:0] w;
        int serr_cnt;
        w = 16'h3C96;
        serr_cnt = 0;
        frame_ready = 1'b1;
        beat(1'b1, 1'b1);
        for (int i = 1; i < 7; i++) beat(1'b1, 1'b0);
        n_checks++;
        if (sel_o !== 4'd7) begin
            n_fail++;
            $display("[TB] FAIL sync_err_setup: got sel=%0d, want 7", sel_o);
        end
        beat(w[0], 1'b1);
        serr_cnt += int'(sync_err);
        n_checks++;
        if (sync_err !== 1'b1 || sel_o !== 4'd1) begin
            n_fail++;
            $display("[TB] FAIL sync_err_pulse: got serr=%b sel=%0d, want 1/1", sync_err, sel_o);
        end
        for (int i = 1; i < 16; i++) begin
            beat(w[i], 1'b0);
            serr_cnt += int'(sync_err);
        end
        n_checks++;
        if (serr_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL sync_err_once: got %0d pulses, want 1", serr_cnt);
        end
        n_checks++;
        if (frame_valid !== 1'b1 || frame_o !== 16'h3C96 || lane_o !== 16'h3C96) begin
            n_fail++;
            $display("[TB] FAIL post_sync_frame: got fv=%b frame=%h lane=%h, want 1/3c96/3c96", frame_valid, frame_o, lane_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        int ov, se, ov_total;
        words[0] = 16'h00FF;
        words[1] = 16'hF00F;
        words[2] = 16'h8001;
        ov_total = 0;
        frame_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            beat(words[f][0], 1'b1);
            ov_total += int'(overrun);
            n_checks++;
            if (frame_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL b2b_drained frame %0d: got fv=%b, want 0", f, frame_valid);
            end
            for (int i = 1; i < 16; i++) begin
                beat(words[f][i], 1'b0);
                ov_total += int'(overrun);
            end
            n_checks++;
            if (frame_valid !== 1'b1 || frame_o !== words[f]) begin
                n_fail++;
                $display("[TB] FAIL b2b_frame %0d: got fv=%b frame=%h, want 1/%h", f, frame_valid, frame_o, words[f]);
            end
        end
        n_checks++;
        if (ov_total !== 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_no_overrun: got %0d pulses, want 0", ov_total);
        end
    endtask

    task automatic test_load_drain();
        logic [15:0] w;
        int ov, se;
        w = 16'h7E81;
        frame_ready = 1'b1;
        send_frame(16'h0F0F, ov, se);
        frame_ready = 1'b0;
        beat(w[0], 1'b1);
        for (int i = 1; i < 15; i++) beat(w[i], 1'b0);
        frame_ready = 1'b1;
        beat(w[15], 1'b0);
        n_checks++;
        if (frame_valid !== 1'b1 || frame_o !== 16'h7E81 || overrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL load_wins: got fv=%b frame=%h ovr=%b, want 1/7e81/0", frame_valid, frame_o, overrun);
        end
        idle();
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL load_wins_drain: got fv=%b, want 0", frame_valid);
        end
    endtask

    task automatic test_gapped();
        logic [15:0] w;
        logic [3:0]  sel_seen;
        w = 16'h5A3C;
        frame_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            beat(w[i], i == 0);
            sel_seen = sel_o;
            if (i == 15) begin
                n_checks++;
                if (frame_valid !== 1'b1 || frame_o !== 16'h5A3C) begin
                    n_fail++;
                    $display("[TB] FAIL gapped_frame: got fv=%b frame=%h, want 1/5a3c", frame_valid, frame_o);
                end
            end
            idle();
            idle();
            n_checks++;
            if (sel_o !== sel_seen || sel_o !== 4'((i + 1) % 16)) begin
                n_fail++;
                $display("[TB] FAIL gapped_sel_hold slot %0d: got sel=%0d, want %0d", i, sel_o, (i + 1) % 16);
            end
        end
        n_checks++;
        if (lane_o !== 16'h5A3C || frame_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gapped_lanes: got lane=%h fv=%b, want 5a3c/0", lane_o, frame_valid);
        end
    endtask

    task automatic test_reset_mid();
        int ov, se;
        frame_ready = 1'b0;
        send_frame(16'hC3A5, ov, se);
        beat(1'b1, 1'b1);
        for (int i = 1; i < 9; i++) beat(1'b1, 1'b0);
        n_checks++;
        if (sel_o !== 4'd9 || frame_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_setup: got sel=%0d fv=%b, want 9/1", sel_o, frame_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sel_o, locked_o, lane_o, frame_o, frame_valid, sync_err, overrun} !== 40'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_async: got sel=%0d locked=%b lane=%h frame=%h fv=%b serr=%b ovr=%b, want all 0",
                     sel_o, locked_o, lane_o, frame_o, frame_valid, sync_err, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 1'b0);
        n_checks++;
        if (locked_o !== 1'b0 || lane_o !== 16'h0 || sel_o !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_hunt: got locked=%b lane=%h sel=%0d, want 0/0000/0", locked_o, lane_o, sel_o);
        end
    endtask

`ifdef TDM_DEMUX_OVR_CNT_EN
    task automatic test_ovr_cnt();
        int ov, se;
        frame_ready = 1'b0;
        for (int f = 0; f < 301; f++) send_frame(16'h6969, ov, se);
        idle();
        n_checks++;
        if (ovr_cnt !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL ovr_cnt_saturate: got %0d, want 255", ovr_cnt);
        end
    endtask
`endif

    initial begin
        $display("[TB] starting tdm_demux_1to16 directed tests");
        test_reset();
        test_hunt();
        test_single_frame();
        test_overrun();
        test_sync_err();
        test_back_to_back();
        test_load_drain();
        test_gapped();
        test_reset_mid();
`ifdef TDM_DEMUX_OVR_CNT_EN
        test_ovr_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1to16.md
# tdm_demux_1to16

Sequential 1-to-16 time-division demultiplexer: the receive-side inverse of the 16:1 mux path. Accepts one serial bit per valid beat from a TDM stream whose slot 0 is flagged by a sync strobe, and routes each bit to its lane register. Assembles each complete 16-slot frame into a one-entry output buffer with a valid/ready handshake.

## Interface
- N_LANES, 16, slot count per frame; fixed at 16 for this block (slot index 4 bits).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit/in_sync qualify this cycle.
- in_sync  in  1  marks current beat as slot 0; meaningful only with in_valid.
- sel_o  out  4  slot index the next accepted beat is routed to.
- locked_o  out  1  1 in LOCKED, 0 in HUNT.
- lane_o  out  16  lane_o[i] = last bit accepted for slot i; holds between beats.
- frame_o  out  16  buffered frame; bit i = slot i.
- frame_valid  out  1  frame_o holds an unconsumed frame.
- frame_ready  in  1  consumer accepts frame_o when high with frame_valid.
- sync_err  out  1  one-cycle pulse: sync seen mid-frame.
- overrun  out  1  one-cycle pulse: completed frame dropped, buffer full.

## Operation
- States: HUNT (reset state), LOCKED.
- HUNT: beats without in_sync ignored; no register changes. Beat with in_sync: bit to slot 0, sel_o -> 1, go LOCKED.
- LOCKED, accepted beat (in_valid=1): lane_o[sel_o] <= in_bit; assembly bit sel_o <= in_bit; sel_o increments mod 16.
- LOCKED, in_sync with sel_o != 0: sync_err pulse; partial frame discarded; beat treated as slot 0 (sel_o -> 1). in_sync with sel_o = 0: normal.
- in_valid=0: no state, lane, or counter change.
- Frame completes on beat accepted at sel_o=15; sel_o wraps to 0; state stays LOCKED.
- On completion: if buffer empty, or frame_valid && frame_ready this cycle, frame_o <= assembled word (slot 15 bit included) and frame_valid=1. Else overrun pulse; new frame dropped; frame_o unchanged.
- Handshake: frame_valid && frame_ready consumes; frame_valid falls next cycle unless reloaded the same cycle. frame_o stable while frame_valid && !frame_ready.
- Reset values: sel_o=0, locked_o=0, lane_o=0, frame_o=0, frame_valid=0, sync_err=0, overrun=0; assembly register 0.

## Timing
- All outputs registered; no combinational input-to-output path.
- lane_o[i] updates the cycle after the accepting edge (1-cycle latency).
- Slot-15 beat at edge k -> frame_valid high after edge k (visible cycle k+1).
- Back-to-back frames at full rate (in_valid=1 every cycle) sustain with frame_ready held high; no bubble.
- Simultaneous completion and drain: load wins, frame_valid stays 1, no overrun.
- Reset asserted mid-frame: immediate clear to reset values; HUNT on release; partial frame lost.

## Configuration
- TDM_DEMUX_OVR_CNT_EN defined: adds output ovr_cnt (8 bits), saturating count of overrun pulses plus sync_err pulses; resets to 0; clears on reset only; holds at 255.
- Undefined: no ovr_cnt port or counter; pulses only.

## Structure
- Shared package tdm_pkg: N_LANES=16, SEL_W=4, state enum {HUNT, LOCKED}, ovr counter width 8.
- One sub-module: tdm_frame_buf (one-entry valid/ready holding register with load/drop/overrun logic). Slot counter, FSM, lane registers in top.

## Test plan
- Reset then 20 beats without in_sync -> locked_o=0, lane_o=0, frame_valid=0 throughout.
- Sync + 16 beats of 16'hA5C3 (slot 0 first, LSB), frame_ready=1 -> frame_o=16'hA5C3, frame_valid one cycle after slot 15, lane_o=16'hA5C3.
- Two back-to-back frames 16'h1234, 16'hFFFF, frame_ready=0 -> frame_o=16'h1234 held, overrun pulse once at second completion.
- in_sync at slot 7 -> sync_err one pulse, sel_o=1 next cycle, next frame_o contains only post-sync bits.
- Gapped in_valid (1 of 3 cycles) over full frame -> same frame_o as contiguous; sel_o constant in idle cycles.
- rst_n low at slot 9 -> all outputs 0 asynchronously; with TDM_DEMUX_OVR_CNT_EN, 300 overruns -> ovr_cnt=255.
